// File: rtl/piece_queue_ctrl.sv
// piece_queue_ctrl: turns the 3-bit LFSR sample stream into a preview queue of
// legal tetromino IDs (0..6) and serves the head piece to the game FSM.
//
// Optional feature macro: NO_REPEAT_EN
//   When defined, a legal sample equal to the most recently pushed ID is
//   rerolled once before being accepted.
//
// Ports:
//   clk         system clock, all logic on posedge
//   reset       synchronous active-low reset (0 = reset)
//   rnd         LFSR output sample
//   lfsr_step   one-cycle request to advance the LFSR
//   pop         game FSM consumes the head piece this cycle
//   head_valid  queue not empty
//   head_piece  piece ID at queue head
//   queue_flat  all entries, [2:0] = head, [3k+2:3k] = entry k
//   count       number of valid entries
//   reject_cnt  saturating count of rejected samples
//   underflow   sticky, pop seen while empty
module piece_queue_ctrl #(
    parameter int unsigned DEPTH = 3,
    parameter int unsigned CNT_W = 8
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [2:0]                 rnd,
    output logic                       lfsr_step,
    input  logic                       pop,
    output logic                       head_valid,
    output logic [2:0]                 head_piece,
    output logic [3*DEPTH-1:0]         queue_flat,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic [CNT_W-1:0]           reject_cnt,
    output logic                       underflow
);

    localparam int unsigned CW      = $clog2(DEPTH + 1);
    localparam logic [2:0]  ILLEGAL = 3'd7;

    typedef enum logic [1:0] {
        DRAW  = 2'd0,
        CHECK = 2'd1,
        FULL  = 2'd2
    } state_t;

    state_t                 state, state_n;
    logic [DEPTH-1:0][2:0]  q, q_n;
    logic [CW-1:0]          count_n;
    logic [CNT_W-1:0]       reject_n;
    logic                   underflow_n;
    logic                   step_n;
    logic                   do_push;
    logic                   do_reject;

`ifdef NO_REPEAT_EN
    logic [2:0]             last_push, last_push_n;
    logic                   reroll_used, reroll_n;
`endif

    // Head outputs decode straight from the entry/count registers.
    assign queue_flat = q;
    assign head_piece = q[0];
    assign head_valid = (count != '0);

    // Next-state, queue update and counters.
    always_comb begin
        state_n     = state;
        q_n         = q;
        count_n     = count;
        reject_n    = reject_cnt;
        underflow_n = underflow;
        do_push     = 1'b0;
        do_reject   = 1'b0;
        // Step request is issued one cycle after DRAW, so it never repeats back to back.
        step_n      = (state == DRAW);
`ifdef NO_REPEAT_EN
        last_push_n = last_push;
        reroll_n    = reroll_used;
`endif

        case (state)
            DRAW: state_n = CHECK;
            CHECK: begin
                if (rnd == ILLEGAL) begin
                    do_reject = 1'b1;
                    state_n   = DRAW;
                end
`ifdef NO_REPEAT_EN
                else if ((rnd == last_push) && !reroll_used) begin
                    // Single reroll of an immediate repeat; 7-rejects above leave the credit alone.
                    do_reject = 1'b1;
                    reroll_n  = 1'b1;
                    state_n   = DRAW;
                end
`endif
                else begin
                    do_push = 1'b1;
                end
            end
            FULL: begin
                if (pop) begin
                    state_n = DRAW;
                end
            end
            default: state_n = DRAW;
        endcase

        // Pop shifts toward the head first so a same-cycle push lands at count-1.
        if (pop) begin
            if (count != '0) begin
                for (int unsigned i = 0; i < DEPTH - 1; i++) begin
                    q_n[i] = q[i+1];
                end
                q_n[DEPTH-1] = '0;
                count_n      = count - CW'(1);
            end else begin
                underflow_n = 1'b1;
            end
        end

        if (do_push) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                if (CW'(i) == count_n) begin
                    q_n[i] = rnd;
                end
            end
            count_n = count_n + CW'(1);
            state_n = (count_n == CW'(DEPTH)) ? FULL : DRAW;
`ifdef NO_REPEAT_EN
            last_push_n = rnd;
            reroll_n    = 1'b0;
`endif
        end

        if (do_reject && (reject_cnt != '1)) begin
            reject_n = reject_cnt + CNT_W'(1);
        end
    end

    // State and datapath registers; reset wins over any pending push or pop.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state      <= DRAW;
            q          <= '0;
            count      <= '0;
            reject_cnt <= '0;
            underflow  <= 1'b0;
            lfsr_step  <= 1'b0;
`ifdef NO_REPEAT_EN
            last_push   <= ILLEGAL;
            reroll_used <= 1'b0;
`endif
        end else begin
            state      <= state_n;
            q          <= q_n;
            count      <= count_n;
            reject_cnt <= reject_n;
            underflow  <= underflow_n;
            lfsr_step  <= step_n;
`ifdef NO_REPEAT_EN
            last_push   <= last_push_n;
            reroll_used <= reroll_n;
`endif
        end
    end

endmodule

// File: tb/tb_piece_queue_ctrl.sv
// Testbench for piece_queue_ctrl: directed scenarios with literal expectations,
// then randomized rnd/pop/reset traffic compared every cycle against a
// queue-based reference model.
module tb_piece_queue_ctrl;

    localparam int unsigned DEPTH = 3;
    localparam int unsigned CNT_W = 8;
    localparam int unsigned CW    = $clog2(DEPTH + 1);
`ifdef NO_REPEAT_EN
    localparam bit NR = 1'b1;
`else
    localparam bit NR = 1'b0;
`endif

    logic                 clk = 1'b0;
    logic                 reset;
    logic [2:0]           rnd;
    logic                 pop;
    logic                 lfsr_step;
    logic                 head_valid;
    logic [2:0]           head_piece;
    logic [3*DEPTH-1:0]   queue_flat;
    logic [CW-1:0]        count;
    logic [CNT_W-1:0]     reject_cnt;
    logic                 underflow;

    int n_checks = 0;
    int n_fail   = 0;

    piece_queue_ctrl #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clk        (clk),
        .reset      (reset),
        .rnd        (rnd),
        .lfsr_step  (lfsr_step),
        .pop        (pop),
        .head_valid (head_valid),
        .head_piece (head_piece),
        .queue_flat (queue_flat),
        .count      (count),
        .reject_cnt (reject_cnt),
        .underflow  (underflow)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: a plain queue plus the draw/sample/idle phase of the sequencer.
    int  mq[$];
    int  m_phase;   // 0 = drawing, 1 = sampling, 2 = idle while full
    int  m_rej;
    bit  m_und;
    bit  m_step;
    int  m_last;
    bit  m_reroll;
    bit  m_live = 1'b0;

    always @(posedge clk) begin
        bit accept;
        int nxt;
        accept = 1'b0;
        if (!reset) begin
            mq.delete();
            m_phase  = 0;
            m_rej    = 0;
            m_und    = 1'b0;
            m_step   = 1'b0;
            m_last   = 7;
            m_reroll = 1'b0;
            m_live   = 1'b1;
        end else if (m_live) begin
            m_step = (m_phase == 0);
            nxt    = m_phase;
            if (m_phase == 0) begin
                nxt = 1;
            end else if (m_phase == 1) begin
                if (int'(rnd) == 7) begin
                    m_rej = (m_rej < 255) ? m_rej + 1 : 255;
                    nxt   = 0;
                end else if (NR && int'(rnd) == m_last && !m_reroll) begin
                    m_rej    = (m_rej < 255) ? m_rej + 1 : 255;
                    m_reroll = 1'b1;
                    nxt      = 0;
                end else begin
                    accept = 1'b1;
                end
            end else if (pop) begin
                nxt = 0;
            end
            if (pop) begin
                if (mq.size() > 0) void'(mq.pop_front());
                else m_und = 1'b1;
            end
            if (accept) begin
                mq.push_back(int'(rnd));
                m_last   = int'(rnd);
                m_reroll = 1'b0;
                nxt      = (mq.size() == DEPTH) ? 2 : 0;
            end
            m_phase = nxt;
        end
    end

    // Every-cycle comparison of all outputs against the model.
    always @(negedge clk) begin
        logic [3*DEPTH-1:0] e_flat;
        if (m_live) begin
            e_flat = '0;
            for (int k = 0; k < mq.size(); k++) e_flat[3*k +: 3] = 3'(mq[k]);
            chk("m_count",      32'(count),      32'(mq.size()));
            chk("m_head_valid", 32'(head_valid), 32'(mq.size() != 0));
            chk("m_head_piece", 32'(head_piece), 32'(e_flat[2:0]));
            chk("m_queue_flat", 32'(queue_flat), 32'(e_flat));
            chk("m_lfsr_step",  32'(lfsr_step),  32'(m_step));
            chk("m_reject_cnt", 32'(reject_cnt), 32'(m_rej));
            chk("m_underflow",  32'(underflow),  32'(m_und));
        end
    end

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        reset = 1'b0;
        pop   = 1'b0;
        rnd   = 3'd0;
        step(3);
        chk("rst_count", 32'(count), 0);
        chk("rst_flat",  32'(queue_flat), 0);
        chk("rst_step",  32'(lfsr_step), 0);

        // Fill 1,2,3 after release.
        reset = 1'b1; rnd = 3'd1;
        step(1);
        chk("fill_step_c1", 32'(lfsr_step), 1);
        chk("fill_hv_c1",   32'(head_valid), 0);
        step(1);
        chk("fill_hv_c2",   32'(head_valid), 1);
        chk("fill_head_c2", 32'(head_piece), 1);
        chk("fill_step_c2", 32'(lfsr_step), 0);
        rnd = 3'd2; step(2);
        rnd = 3'd3; step(2);
        chk("fill_count", 32'(count), 3);
        chk("fill_flat",  32'(queue_flat), 32'(9'b011_010_001));

        // Pop while full, refill with 5.
        pop = 1'b1; rnd = 3'd5; step(1); pop = 1'b0;
        chk("popfull_head",  32'(head_piece), 2);
        chk("popfull_count", 32'(count), 2);
        step(2);
        chk("refill_flat", 32'(queue_flat), 32'(9'b101_011_010));

        // Pop, reject a 7, then pop+push 4 in the same sampling cycle.
        pop = 1'b1; rnd = 3'd7; step(1); pop = 1'b0;
        step(2);
        chk("reject_cnt1", 32'(reject_cnt), 1);
        rnd = 3'd4; step(1);
        pop = 1'b1; step(1); pop = 1'b0;
        chk("simul_flat",  32'(queue_flat), 32'(9'b000_100_101));
        chk("simul_count", 32'(count), 2);

        // Immediate repeat of 4.
        step(2);
        chk("repeat_count", 32'(count), NR ? 2 : 3);
        chk("repeat_rej",   32'(reject_cnt), NR ? 2 : 1);
        step(2);
        chk("repeat_count2", 32'(count), 3);

        // Drain to empty and pop once more; then saturate the reject counter.
        rnd = 3'd7; pop = 1'b1; step(4); pop = 1'b0;
        chk("uf_count", 32'(count), 0);
        chk("uf_flag",  32'(underflow), 1);
        step(600);
        chk("sat_rej", 32'(reject_cnt), 255);

        // Reset during a sampling cycle with a legal sample pending.
        for (int i = 0; i < 4 && m_phase != 1; i++) step(1);
        chk("mid_phase", 32'(m_phase), 1);
        rnd = 3'd3; reset = 1'b0; step(1);
        chk("midrst_count", 32'(count), 0);
        chk("midrst_flat",  32'(queue_flat), 0);
        chk("midrst_uf",    32'(underflow), 0);
        chk("midrst_rej",   32'(reject_cnt), 0);
        chk("midrst_step",  32'(lfsr_step), 0);
        reset = 1'b1;

        // Randomized traffic.
        for (int c = 0; c < 4000; c++) begin
            rnd   = 3'($urandom_range(0, 7));
            pop   = ($urandom_range(0, 9) < 3);
            reset = ($urandom_range(0, 299) != 0);
            step(1);
        end
        reset = 1'b1; pop = 1'b0;
        step(2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
